// File: rtl/alu_test_pkg.sv
// alu_test_pkg: constants and types shared by the ALU pattern engine.
// Holds ALU opcode/bonus encodings, pattern-record byte offsets and the engine FSM state type.
// No ports; imported by alu_pattern_fetch and alu_pattern_engine.
package alu_test_pkg;

  // ALU operation codes
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd12;
  localparam logic [3:0] OP_NAND = 4'd13;

  // compare sub-selects used with OP_SLT
  localparam logic [2:0] BON_SLT = 3'd0;
  localparam logic [2:0] BON_SGT = 3'd1;
  localparam logic [2:0] BON_SLE = 3'd2;
  localparam logic [2:0] BON_SGE = 3'd3;
  localparam logic [2:0] BON_SNE = 3'd4;
  localparam logic [2:0] BON_SEQ = 3'd6;

  // pattern record layout (byte offsets inside one record)
  localparam int RECORD_BYTES = 16;
  localparam int FETCH_BYTES  = 15;   // byte 15 is reserved and never read
  localparam int OFF_SRC1     = 0;
  localparam int OFF_SRC2     = 4;
  localparam int OFF_OP       = 8;
  localparam int OFF_BONUS    = 9;
  localparam int OFF_EXP      = 10;
  localparam int OFF_ZCV      = 14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_APPLY,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/alu_pattern_fetch.sv
// alu_pattern_fetch: walks one 16-byte pattern record and captures bytes 0..14 into staging regs.
// Ports: fetch_start/fetch_idx launch a fetch, mem_addr/mem_rdata talk to the registered-read
// memory, fetch_done flags the last fetch cycle, f_* are the assembled staging fields.
module alu_pattern_fetch
  import alu_test_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_start,
  input  logic [3:0]    fetch_idx,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          fetch_done,
  output logic [31:0]   f_src1,
  output logic [31:0]   f_src2,
  output logic [3:0]    f_opcode,
  output logic [2:0]    f_bonus,
  output logic [31:0]   f_exp_result,
  output logic [2:0]    f_exp_zcv
);

  logic       active;
  logic [3:0] cnt;                 // FETCH cycle number, 0..15
  logic [7:0] stg [FETCH_BYTES];

  // Address for offset k is on the bus in fetch cycle k; its data returns in cycle k+1 and is
  // captured at the end of that cycle. Offset 14 lands at the end of cycle 15, so a fetch is
  // exactly 16 cycles. The address stops at base+14 so the reserved byte is never read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      cnt      <= 4'd0;
      mem_addr <= '0;
      for (int i = 0; i < FETCH_BYTES; i++) stg[i] <= 8'd0;
    end else if (fetch_start) begin
      active   <= 1'b1;
      cnt      <= 4'd0;
      mem_addr <= AW'({fetch_idx, 4'b0000});
    end else if (active) begin
      cnt <= cnt + 4'd1;
      if (cnt < 4'(FETCH_BYTES - 1)) mem_addr <= mem_addr + AW'(1);
      if (cnt != 4'd0) stg[cnt - 4'd1] <= mem_rdata;
      if (cnt == 4'(RECORD_BYTES - 1)) active <= 1'b0;
    end
  end

  assign fetch_done = active && (cnt == 4'(RECORD_BYTES - 1));

  assign f_src1       = {stg[OFF_SRC1+3], stg[OFF_SRC1+2], stg[OFF_SRC1+1], stg[OFF_SRC1]};
  assign f_src2       = {stg[OFF_SRC2+3], stg[OFF_SRC2+2], stg[OFF_SRC2+1], stg[OFF_SRC2]};
  assign f_opcode     = stg[OFF_OP][3:0];
  assign f_bonus      = stg[OFF_BONUS][2:0];
  assign f_exp_result = {stg[OFF_EXP+3], stg[OFF_EXP+2], stg[OFF_EXP+1], stg[OFF_EXP]};
  assign f_exp_zcv    = stg[OFF_ZCV][2:0];

endmodule

// File: rtl/alu_pattern_engine.sv
// alu_pattern_engine: drives ALU operands from stored patterns and checks its results/flags.
// Ports: start launches a run; mem_addr/mem_rdata fetch patterns; src1/src2/alu_control/
// bonus_control drive the ALU; result/zero/cout/overflow are checked; busy/done/pass/err_* report.
module alu_pattern_engine
  import alu_test_pkg::*;
#(
  parameter int PATTERN_NUM = 11,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic [31:0]   src1,
  output logic [31:0]   src2,
  output logic [3:0]    alu_control,
  output logic [2:0]    bonus_control,
  input  logic [31:0]   result,
  input  logic          zero,
  input  logic          cout,
  input  logic          overflow,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [7:0]    err_count,
  output logic          err_valid,
  output logic [5:0]    err_index
);

  state_t      state, state_nxt;
  logic [3:0]  pat_idx, pat_nxt;
  logic        fetch_start, run_start, fetch_done, mismatch, last_pat;
  logic [31:0] f_src1, f_src2, f_exp_result;
  logic [3:0]  f_opcode;
  logic [2:0]  f_bonus, f_exp_zcv;

  alu_pattern_fetch #(.AW(AW)) u_fetch (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_start  (fetch_start),
    .fetch_idx    (pat_nxt),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .fetch_done   (fetch_done),
    .f_src1       (f_src1),
    .f_src2       (f_src2),
    .f_opcode     (f_opcode),
    .f_bonus      (f_bonus),
    .f_exp_result (f_exp_result),
    .f_exp_zcv    (f_exp_zcv)
  );

  assign last_pat = (pat_idx == 4'(PATTERN_NUM - 1));

  // One error per pattern at most: result first, then full flags for ADD/SUB, else zero only.
  // The staging regs still hold this pattern's expectations: the next fetch starts after CHECK.
  always_comb begin
    mismatch = 1'b0;
    if (result != f_exp_result)
      mismatch = 1'b1;
    else if (alu_control == OP_ADD || alu_control == OP_SUB)
      mismatch = ({zero, cout, overflow} != f_exp_zcv);
    else
      mismatch = (zero != f_exp_zcv[2]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pat_idx <= 4'd0;
    end else begin
      state   <= state_nxt;
      pat_idx <= pat_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pat_nxt     = pat_idx;
    fetch_start = 1'b0;
    run_start   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    err_valid   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          state_nxt   = ST_FETCH;
          pat_nxt     = 4'd0;
          fetch_start = 1'b1;
          run_start   = 1'b1;
        end
      end
      ST_FETCH: begin
        busy = 1'b1;
        if (fetch_done) state_nxt = ST_APPLY;
      end
      ST_APPLY: begin
        busy      = 1'b1;
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy      = 1'b1;
        state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy      = 1'b1;
        err_valid = mismatch;
        if (last_pat) begin
          state_nxt = ST_DONE;
        end else begin
          state_nxt   = ST_FETCH;
          pat_nxt     = pat_idx + 4'd1;
          fetch_start = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // ALU inputs are only ever loaded here, all together, so the ALU never sees a mixed pattern.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src1          <= 32'd0;
      src2          <= 32'd0;
      alu_control   <= 4'd0;
      bonus_control <= 3'd0;
    end else if (state == ST_APPLY) begin
      src1          <= f_src1;
      src2          <= f_src2;
      alu_control   <= f_opcode;
      bonus_control <= f_bonus;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_count <= 8'd0;
      err_index <= 6'd0;
    end else if (run_start) begin
      err_count <= 8'd0;
      err_index <= 6'd0;
    end else if (err_valid) begin
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      err_index <= {2'b00, pat_idx} + 6'd1;
    end
  end

  assign pass = done && (err_count == 8'd0);

endmodule

// File: doc/alu_pattern_engine.md
# alu_pattern_engine

Synthesizable stimulus-and-check engine that sits directly upstream of the ALU and also consumes its outputs. It fetches test patterns byte-serially from an 8-bit pattern memory, drives src1/src2/ALU_control/bonus_control, samples result/zero/cout/overflow after a settle cycle, and compares them against expected values. It counts mismatches and reports pass/fail, so the ALU can be self-checked on an FPGA without a simulator bench.

## Interface
- PATTERN_NUM, 11, number of patterns to run; legal range 1..16.
- AW, 8, pattern memory address width; must satisfy 2^AW ≥ PATTERN_NUM*16.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- mem_addr  out  AW  pattern memory byte address.
- mem_rdata  in  8  memory read data, valid one cycle after mem_addr (registered read).
- src1  out  32  ALU operand 1.
- src2  out  32  ALU operand 2.
- alu_control  out  4  ALU operation code.
- bonus_control  out  3  ALU compare sub-select.
- result  in  32  ALU result.
- zero, cout, overflow  in  1 each  ALU flags.
- busy  out  1  high from the first FETCH cycle through CHECK of the last pattern.
- done  out  1  high in DONE state; held until the next start.
- pass  out  1  done && (err_count == 0).
- err_count  out  8  mismatches this run; saturates at 255.
- err_valid  out  1  one-cycle pulse in CHECK when the current pattern fails.
- err_index  out  6  1-based pattern number of the most recent failure.

## Operation
- Record layout: pattern i at base i*16. Offsets: 0–3 src1, LSB first. 4–7 src2, LSB first. 8 opcode in bits[3:0]. 9 bonus in bits[2:0]. 10–13 expected result, LSB first. 14 expected {z,c,v} in bits[2:0]. 15 reserved, never read.
- FSM states: IDLE → FETCH → APPLY → SETTLE → CHECK → (FETCH for next pattern | DONE). DONE → FETCH on start. Reset from any state → IDLE.
- FETCH: issues offsets 0..14 on consecutive cycles and captures each returned byte into staging registers one cycle later. Lasts 16 cycles.
- APPLY: copies staging registers to src1/src2/alu_control/bonus_control in a single cycle. ALU inputs change only here, atomically.
- SETTLE: one idle cycle for ALU propagation.
- CHECK: evaluates in priority order; at most one error per pattern.
  - result ≠ expected → error.
  - else if opcode ∈ {2 (ADD), 6 (SUB)} and {zero,cout,overflow} ≠ expected zcv → error.
  - else if zero ≠ expected z → error.
  - cout/overflow are ignored for all other opcodes.
- On error in CHECK: err_valid=1, err_count increments with saturation, err_index = pattern number.
- start in IDLE or DONE clears err_count, err_index and done, then enters FETCH for pattern 0. start while busy is ignored.
- Reset values: mem_addr 0, src1/src2 0, alu_control 0, bonus_control 0, busy 0, done 0, pass 0, err_count 0, err_valid 0, err_index 0, staging registers 0, state IDLE.

## Timing
- Each pattern takes exactly 19 cycles: 16 FETCH, 1 APPLY, 1 SETTLE, 1 CHECK.
- done rises on the edge 19*PATTERN_NUM after the edge that samples start. busy falls on that same edge.
- ALU inputs are stable from APPLY through CHECK, so the sampled outputs correspond to the current pattern.
- Reset asserted mid-run: on the next edge all outputs return to reset values. A partial run is discarded and a new start is required.
- start held high continuously: a new run starts one cycle after each DONE is entered. done is high for one cycle per run.
- Pattern counter wraps to DONE after PATTERN_NUM-1; it never addresses beyond PATTERN_NUM*16-1.

## Structure
- Shared package alu_test_pkg:
  - opcode constants: AND 0, OR 1, ADD 2, SUB 6, SLT 7, NOR 12, NAND 13;
  - bonus constants: SLT 0, SGT 1, SLE 2, SGE 3, SNE 4, SEQ 6;
  - record offset constants and RECORD_BYTES=16;
  - FSM state enum.
- Sub-module alu_pattern_fetch: address counter, byte-lane capture, and 15-byte staging register file. It exposes fetch_start, fetch_done and the assembled fields. The top level holds the FSM, APPLY/CHECK logic and counters.

## Test plan
- Single ADD pattern: src1=0x7FFFFFFF, src2=0x00000001, op=2, expected 0x80000000, zcv=001, ideal ALU model → done at cycle 19, pass=1, err_count=0.
- SUB with wrong flag: ALU model forces cout=0 where expected zcv=110 for 5−5 → err_valid pulse in CHECK of pattern 1, err_index=1, err_count=1, pass=0.
- AND with wrong cout only: op=0, expected zcv=000, ALU drives cout=1 → no error, because flags other than zero are ignored for non-ADD/SUB opcodes.
- Full 11-pattern run, ALU result bit 0 stuck-at-1 on patterns 3 and 7 → err_count=2, err_index=7, done at cycle 209.
- Reset asserted at cycle 30 of a run → next cycle busy=0, src1=0, err_count=0, state IDLE. start restarts from pattern 0.
- start pulsed during busy at cycle 10 → ignored, run completes at cycle 19*PATTERN_NUM. A second start in DONE clears err_count and reruns.
